// File: rtl/i2c_pkg.sv
// Shared types and default constants for the I2C receive-side line conditioning.
// Pure declarations; no logic, no latency, no backpressure.
package i2c_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_t;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int FILTER_LEN_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 100000;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Synchronises one asynchronous pad line and accepts a new level only after FILTER_LEN stable samples.
// Latency SYNC_STAGES+FILTER_LEN cycles pad-to-q_filt; free-running, no backpressure.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic d_in,
  output logic q_filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  // Lines idle high, so the chain and filtered level come out of reset at 1.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      q_filt <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      if (synced == q_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        q_filt <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_line_conditioner.sv
// Conditions raw SCL/SDA pads into filtered levels, edge/bit/START/STOP strobes, bus-busy and stuck-SCL flags.
// Strobes 1 cycle after the filtered change (SYNC_STAGES+FILTER_LEN+1 from pad); no backpressure.
module i2c_line_conditioner
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_filt,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic bit_valid,
  output logic bit_value,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic scl_stuck_low
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] STUCK_MAX = TW'(TIMEOUT_CYCLES);

  logic          scl_q;
  logic          sda_q;
  logic [TW-1:0] stuck_cnt;
  logic          stuck_q;
  logic          stuck_rise;
  bus_state_t    state;
  bus_state_t    state_nxt;

  i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filter (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .d_in     (scl_in),
    .q_filt   (scl_filt)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filter (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .d_in     (sda_in),
    .q_filt   (sda_filt)
  );

  assign scl_stuck_low = (stuck_cnt == STUCK_MAX);
  assign stuck_rise    = scl_stuck_low & ~stuck_q;
  assign bus_busy      = (state == BUSY);

  // Delayed copies reset to 1 so leaving reset on an idle bus produces no edges.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      bit_valid <= 1'b0;
      bit_value <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_q     <= scl_filt;
      sda_q     <= sda_filt;
      scl_rise  <= scl_filt & ~scl_q;
      scl_fall  <= ~scl_filt & scl_q;
      bit_valid <= scl_filt & ~scl_q;
      if (scl_filt && !scl_q) begin
        bit_value <= sda_filt;
      end
      // SCL must be high on both sides of the SDA edge; a shared-cycle change is data, not a condition.
      start_det <= sda_q & ~sda_filt & scl_q & scl_filt;
      stop_det  <= ~sda_q & sda_filt & scl_q & scl_filt;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      stuck_cnt <= '0;
      stuck_q   <= 1'b0;
    end else begin
      stuck_q <= scl_stuck_low;
      if (scl_filt) begin
        stuck_cnt <= '0;
      end else if (stuck_cnt != STUCK_MAX) begin
        stuck_cnt <= stuck_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_det) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (stop_det || stuck_rise) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Self-checking bench for i2c_line_conditioner with FILTER_LEN=4, TIMEOUT_CYCLES=1000.
module tb_i2c_line_conditioner;

  logic clock_in;
  logic reset_n;
  logic scl_in;
  logic sda_in;
  logic scl_filt, sda_filt, scl_rise, scl_fall, bit_valid, bit_value;
  logic start_det, stop_det, bus_busy, scl_stuck_low;

  int n_vec;
  int n_err;
  int n_rise, n_fall, n_start, n_stop, n_valid;
  logic exp_q[$];

  logic [9:0] outs;
  localparam logic [9:0] RST_VAL = 10'b11_0000_0000;
  assign outs = {scl_filt, sda_filt, scl_rise, scl_fall, bit_valid, bit_value,
                 start_det, stop_det, bus_busy, scl_stuck_low};

  i2c_line_conditioner #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clock_in      (clock_in),
    .reset_n       (reset_n),
    .scl_in        (scl_in),
    .sda_in        (sda_in),
    .scl_filt      (scl_filt),
    .sda_filt      (sda_filt),
    .scl_rise      (scl_rise),
    .scl_fall      (scl_fall),
    .bit_valid     (bit_valid),
    .bit_value     (bit_value),
    .start_det     (start_det),
    .stop_det      (stop_det),
    .bus_busy      (bus_busy),
    .scl_stuck_low (scl_stuck_low)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Strobe counters and bit scoreboard, sampled on the falling edge.
  always @(negedge clock_in) begin
    if (reset_n) begin
      if (scl_rise)  n_rise++;
      if (scl_fall)  n_fall++;
      if (start_det) n_start++;
      if (stop_det)  n_stop++;
      if (bit_valid || scl_rise) begin
        n_vec++;
        if (bit_valid !== scl_rise) begin
          n_err++;
          $display("FAIL bit_valid_vs_rise: bit_valid=%b scl_rise=%b", bit_valid, scl_rise);
        end
      end
      if (bit_valid) begin
        n_valid++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bit_unexpected: got bit_value=%b with no bit expected", bit_value);
        end else begin
          logic e;
          e = exp_q.pop_front();
          if (bit_value !== e) begin
            n_err++;
            $display("FAIL bit_value: got %b expected %b", bit_value, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic clr();
    n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_valid = 0;
  endtask

  // One SCL pulse: 20 cycles low (SDA changes mid-low), 20 high.
  task automatic send_bit(input logic b);
    scl_in = 1'b0;
    tick(10);
    sda_in = b;
    tick(10);
    exp_q.push_back(b);
    scl_in = 1'b1;
    tick(20);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    scl_in  = 1'b1;
    sda_in  = 1'b1;
    tick(3);
    n_vec++;
    if (outs !== RST_VAL) begin
      n_err++;
      $display("FAIL reset_values: got %b expected %b", outs, RST_VAL);
    end
    reset_n = 1'b1;
    tick(5);
    n_vec++;
    if (outs !== RST_VAL) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b expected %b", outs, RST_VAL);
    end
  endtask

  task automatic test_glitch();
    logic low_seen;
    clr();
    scl_in = 1'b0;
    tick(3);
    scl_in = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (scl_filt !== 1'b1) low_seen = 1'b1;
    end
    n_vec++;
    if (low_seen) begin
      n_err++;
      $display("FAIL glitch3_filt: got scl_filt low expected stays 1");
    end
    n_vec++;
    if (n_fall != 0 || n_rise != 0) begin
      n_err++;
      $display("FAIL glitch3_strobes: got fall=%0d rise=%0d expected 0 0", n_fall, n_rise);
    end
    // 4-cycle pulse is accepted: filt falls at cycle 6, scl_fall at cycle 7.
    scl_in = 1'b0;
    tick(4);
    exp_q.push_back(1'b1);
    scl_in = 1'b1;
    tick(1);
    n_vec++;
    if (scl_filt !== 1'b1) begin
      n_err++;
      $display("FAIL pulse4_c5_filt: got %b expected 1", scl_filt);
    end
    tick(1);
    n_vec++;
    if ({scl_filt, scl_fall} !== 2'b00) begin
      n_err++;
      $display("FAIL pulse4_c6: got filt,fall=%b expected 00", {scl_filt, scl_fall});
    end
    tick(1);
    n_vec++;
    if (scl_fall !== 1'b1) begin
      n_err++;
      $display("FAIL pulse4_c7_fall: got %b expected 1", scl_fall);
    end
    tick(1);
    n_vec++;
    if (scl_fall !== 1'b0) begin
      n_err++;
      $display("FAIL pulse4_c8_fall: got %b expected 0", scl_fall);
    end
    tick(20);
    n_vec++;
    if (n_fall != 1 || n_rise != 1 || scl_filt !== 1'b1) begin
      n_err++;
      $display("FAIL pulse4_strobes: got fall=%0d rise=%0d filt=%b expected 1 1 1", n_fall, n_rise, scl_filt);
    end
  endtask

  task automatic test_start_stop();
    clr();
    sda_in = 1'b0;
    tick(12);
    n_vec++;
    if (n_start != 1 || n_stop != 0 || bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL start: got start=%0d stop=%0d busy=%b expected 1 0 1", n_start, n_stop, bus_busy);
    end
    sda_in = 1'b1;
    tick(12);
    n_vec++;
    if (n_start != 1 || n_stop != 1 || bus_busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop: got start=%0d stop=%0d busy=%b expected 1 1 0", n_start, n_stop, bus_busy);
    end
  endtask

  task automatic test_byte_a5();
    logic [7:0] b;
    b = 8'hA5;
    sda_in = 1'b0;
    tick(12);
    n_vec++;
    if (bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL byte_start_busy: got %b expected 1", bus_busy);
    end
    clr();
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(5);
    n_vec++;
    if (n_valid != 8 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL byte_count: got valid=%0d pending=%0d expected 8 0", n_valid, exp_q.size());
    end
    n_vec++;
    if (n_start != 0 || n_stop != 0 || bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL byte_no_cond: got start=%0d stop=%0d busy=%b expected 0 0 1", n_start, n_stop, bus_busy);
    end
  endtask

  task automatic test_simultaneous();
    logic busy_drop;
    clr();
    busy_drop = 1'b0;
    scl_in = 1'b0;
    sda_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus_busy !== 1'b1) busy_drop = 1'b1;
    end
    n_vec++;
    if (n_fall != 1 || n_start != 0 || busy_drop) begin
      n_err++;
      $display("FAIL simult: got fall=%0d start=%0d busy_drop=%b expected 1 0 0", n_fall, n_start, busy_drop);
    end
    // Repeated START while already busy.
    sda_in = 1'b1;
    tick(10);
    exp_q.push_back(1'b1);
    scl_in = 1'b1;
    tick(10);
    clr();
    sda_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus_busy !== 1'b1) busy_drop = 1'b1;
    end
    n_vec++;
    if (n_start != 1 || n_stop != 0 || busy_drop) begin
      n_err++;
      $display("FAIL rep_start: got start=%0d stop=%0d busy_drop=%b expected 1 0 0", n_start, n_stop, busy_drop);
    end
  endtask

  task automatic test_stuck();
    int k;
    bit found;
    scl_in = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (scl_filt === 1'b0) found = 1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL stuck_filt_fall: got scl_filt=%b expected 0 within 20 cycles", scl_filt);
    end
    k = 0;
    found = 0;
    while (k < 1100 && !found) begin
      tick(1);
      k++;
      if (scl_stuck_low === 1'b1) found = 1;
    end
    n_vec++;
    if (k != 1000) begin
      n_err++;
      $display("FAIL stuck_delay: got %0d cycles expected 1000", k);
    end
    n_vec++;
    if (bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL stuck_busy_same: got %b expected 1", bus_busy);
    end
    tick(1);
    n_vec++;
    if (bus_busy !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_busy_next: got %b expected 0", bus_busy);
    end
    tick(190);
    n_vec++;
    if (scl_stuck_low !== 1'b1) begin
      n_err++;
      $display("FAIL stuck_hold: got %b expected 1", scl_stuck_low);
    end
    exp_q.push_back(1'b0);
    scl_in = 1'b1;
    tick(10);
    n_vec++;
    if (scl_stuck_low !== 1'b0 || bus_busy !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_clear: got stuck=%b busy=%b expected 0 0", scl_stuck_low, bus_busy);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    sda_in = 1'b1;
    tick(12);
    n_vec++;
    if (n_stop != 1 || bus_busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_stop: got stop=%0d busy=%b expected 1 0", n_stop, bus_busy);
    end
    sda_in = 1'b0;
    tick(12);
    n_vec++;
    if (bus_busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_start_busy: got %b expected 1", bus_busy);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    scl_in = 1'b0;
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (outs !== RST_VAL) begin
      n_err++;
      $display("FAIL async_reset: got %b expected %b", outs, RST_VAL);
    end
    scl_in = 1'b1;
    sda_in = 1'b1;
    tick(3);
    reset_n = 1'b1;
    clr();
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_vec++;
      if ({scl_rise, scl_fall, bit_valid, start_det, stop_det} !== 5'b0) begin
        n_err++;
        $display("FAIL release_strobes: cycle %0d got %b expected 00000", i,
                 {scl_rise, scl_fall, bit_valid, start_det, stop_det});
      end
    end
    n_vec++;
    if (bus_busy !== 1'b0 || bit_value !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL release_state: got busy=%b bit_value=%b pending=%0d expected 0 0 0",
               bus_busy, bit_value, exp_q.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr();
    reset_n = 1'b0;
    scl_in  = 1'b1;
    sda_in  = 1'b1;
    test_reset();
    test_glitch();
    test_start_stop();
    test_byte_a5();
    test_simultaneous();
    test_stuck();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
